threshold_sweep_controller: RTL

- Sequences the programmable threshold voltage sensor.
- Drives the 3-bit threshold select code into the level decoder and waits a settling interval at each level.
- Majority-samples the synchronized comparator output, then steps through all 8 levels.
- Reports a thermometer word, a level count and a monotonicity (bubble) flag. Sits between the digital pins and the decoder/analog comparator pair.

---
 rtl/tsc_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/threshold_sweep_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tsc_pkg.sv
// Shared constants, state encoding and helpers for the threshold sweep controller.
package tsc_pkg;

  localparam int unsigned CODE_W     = 3;
  localparam int unsigned NUM_LEVELS = 8;
  localparam int unsigned LEVEL_W    = 4;
  localparam int unsigned STATE_W    = 2;

  // Controller state encoding
  localparam logic [STATE_W-1:0] IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] SETTLE = 2'd1;
  localparam logic [STATE_W-1:0] SAMPLE = 2'd2;
  localparam logic [STATE_W-1:0] DONE   = 2'd3;

  // Number of set bits in a per-level decision vector
  function automatic logic [LEVEL_W-1:0] popcount(input logic [NUM_LEVELS-1:0] v);
    logic [LEVEL_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(NUM_LEVELS); i++) begin
      n = n + LEVEL_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Metastability filter: d -> s1 -> q
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/threshold_sweep_controller.sv
// Steps the threshold code through all levels, settles, majority-samples the
// synchronized comparator and publishes a thermometer word per sweep.
module threshold_sweep_controller
  import tsc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SAMPLES       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  cmp_in,
  output logic [CODE_W-1:0]     code_out,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [NUM_LEVELS-1:0] therm,
  output logic [LEVEL_W-1:0]    level,
  output logic                  bubble
);

  localparam int unsigned SET_W  = 8;
  localparam int unsigned SMP_W  = 4;
  localparam int unsigned ONES_W = SMP_W + 1;

  localparam logic [SET_W-1:0]  SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0]  SMP_INIT    = SMP_W'(SAMPLES - 1);
  localparam logic [CODE_W-1:0] LAST_CODE   = CODE_W'(NUM_LEVELS - 1);

  logic cmp_s;

  logic [STATE_W-1:0]    state, state_n;
  logic [CODE_W-1:0]     code_n;
  logic [SET_W-1:0]      set_cnt, set_cnt_n;
  logic [SMP_W-1:0]      smp_cnt, smp_cnt_n;
  logic [SMP_W-1:0]      ones, ones_n;
  logic [NUM_LEVELS-1:0] working, working_n, working_upd;
  logic [NUM_LEVELS-1:0] therm_n;
  logic [LEVEL_W-1:0]    level_n;
  logic                  bubble_n, valid_n, done_n, busy_n;
  logic [ONES_W-1:0]     ones_sum;
  logic                  maj;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (cmp_s)
  );

  // Majority over this level's samples, including the current one; ties resolve to 0
  always_comb begin
    ones_sum    = ONES_W'(ones) + ONES_W'(cmp_s);
    maj         = ({ones_sum, 1'b0} > (ONES_W + 1)'(SAMPLES));
    working_upd = working;
    working_upd[code_out] = maj;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    code_n    = code_out;
    set_cnt_n = set_cnt;
    smp_cnt_n = smp_cnt;
    ones_n    = ones;
    working_n = working;
    therm_n   = therm;
    level_n   = level;
    bubble_n  = bubble;
    valid_n   = valid;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        code_n = '0;
        if (start) begin
          state_n   = SETTLE;
          set_cnt_n = SETTLE_INIT;
          working_n = '0;
        end
      end
      SETTLE: begin
        if (set_cnt == '0) begin
          state_n   = SAMPLE;
          smp_cnt_n = SMP_INIT;
          ones_n    = '0;
        end else begin
          set_cnt_n = set_cnt - SET_W'(1);
        end
      end
      SAMPLE: begin
        if (smp_cnt == '0) begin
          working_n = working_upd;
          if (code_out == LAST_CODE) begin
            // Results are published on entry so they are visible during the DONE cycle
            state_n  = DONE;
            therm_n  = working_upd;
            level_n  = popcount(working_upd);
            bubble_n = ((working_upd & (working_upd + NUM_LEVELS'(1))) != '0);
            valid_n  = 1'b1;
            done_n   = 1'b1;
          end else begin
            state_n   = SETTLE;
            code_n    = code_out + CODE_W'(1);
            set_cnt_n = SETTLE_INIT;
          end
        end else begin
          ones_n    = ones_sum[SMP_W-1:0];
          smp_cnt_n = smp_cnt - SMP_W'(1);
        end
      end
      DONE: begin
        code_n = '0;
        if (cont) begin
          state_n   = SETTLE;
          set_cnt_n = SETTLE_INIT;
          working_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        code_n  = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      code_out <= '0;
      set_cnt  <= '0;
      smp_cnt  <= '0;
      ones     <= '0;
      working  <= '0;
      therm    <= '0;
      level    <= '0;
      bubble   <= 1'b0;
      valid    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      code_out <= code_n;
      set_cnt  <= set_cnt_n;
      smp_cnt  <= smp_cnt_n;
      ones     <= ones_n;
      working  <= working_n;
      therm    <= therm_n;
      level    <= level_n;
      bubble   <= bubble_n;
      valid    <= valid_n;
      done     <= done_n;
      busy     <= busy_n;
    end
  end

endmodule
